// File: rtl/sram_scan_ctrl_if.sv
// SRAM-side bus of the scan controller: per-macro chip selects, shared port
// controls and the packed read-data buses returned by the macro array.
interface sram_scan_ctrl_if #(
  parameter int unsigned NUM_MACROS = 12,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32
);
  logic [NUM_MACROS-1:0]        macro_csb0;
  logic [NUM_MACROS-1:0]        macro_csb1;
  logic                         web0;
  logic                         web1;
  logic [3:0]                   wmask0;
  logic [3:0]                   wmask1;
  logic [ADDR_W-1:0]            addr0;
  logic [ADDR_W-1:0]            addr1;
  logic [DATA_W-1:0]            din0;
  logic [DATA_W-1:0]            din1;
  logic [NUM_MACROS*DATA_W-1:0] dout0_bus;
  logic [NUM_MACROS*DATA_W-1:0] dout1_bus;

  modport master (
    output macro_csb0, macro_csb1, web0, web1, wmask0, wmask1,
           addr0, addr1, din0, din1,
    input  dout0_bus, dout1_bus
  );

  modport slave (
    input  macro_csb0, macro_csb1, web0, web1, wmask0, wmask1,
           addr0, addr1, din0, din1,
    output dout0_bus, dout1_bus
  );
endinterface

// File: rtl/sram_scan_ctrl.sv
// Scan-chain SRAM test controller: a shifted-in command packet is issued as one
// access cycle to the selected macro and read data is captured back into the packet.
module sram_scan_ctrl #(
  parameter int unsigned NUM_MACROS = 12,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             csb_n,
  input  logic             sram_load,
  output logic             busy,
  output logic             sel_err,
  sram_scan_ctrl_if.master sram
);

  localparam int unsigned PKT_W = 4 + 2 * (ADDR_W + DATA_W + 6);
  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef struct packed {
    logic [3:0]        sel;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] din0;
    logic              csb0;
    logic              web0;
    logic [3:0]        wmask0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] din1;
    logic              csb1;
    logic              web1;
    logic [3:0]        wmask1;
  } pkt_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              load_pend, load_pend_next;
  logic              issue_go, capt_go;

  pkt_t              shreg;
  logic              csb_n_q;
  logic [3:0]        sel_q;
  logic              sel_ok_q, rd0_q, rd1_q;

  logic              sel_ok;
  logic [NUM_MACROS-1:0] csb0_pick, csb1_pick;
  logic [DATA_W-1:0] dout0_sel, dout1_sel;

  assign scan_out = shreg[PKT_W-1];
  assign sel_ok   = (32'(shreg.sel) < NUM_MACROS);

  always_comb begin
    csb0_pick = '1;
    csb1_pick = '1;
    dout0_sel = '0;
    dout1_sel = '0;
    for (int unsigned k = 0; k < NUM_MACROS; k++) begin
      if (32'(shreg.sel) == k) begin
        csb0_pick[k] = shreg.csb0;
        csb1_pick[k] = shreg.csb1;
      end
      if (32'(sel_q) == k) begin
        dout0_sel = sram.dout0_bus[k*DATA_W +: DATA_W];
        dout1_sel = sram.dout1_bus[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      load_pend <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      load_pend <= load_pend_next;
      busy      <= (state_next != S_IDLE);
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    load_pend_next = load_pend;
    issue_go       = 1'b0;
    capt_go        = 1'b0;
    if (scan_en) begin
      state_next     = S_IDLE;
      load_pend_next = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (csb_n_q && !csb_n) begin
            state_next = S_ISSUE;
            issue_go   = 1'b1;
          end
        end
        S_ISSUE: begin
          load_pend_next = 1'b0;
          if (sel_ok_q && (rd0_q || rd1_q)) begin
            state_next = S_WAIT;
            cnt_next   = CNT_W'(READ_LAT - 1);
          end else begin
            state_next = S_IDLE;
          end
        end
        S_WAIT: begin
          if (sram_load) load_pend_next = 1'b1;
          if (cnt == '0) state_next = S_CAPT;
          else           cnt_next   = cnt - 1'b1;
        end
        S_CAPT: begin
          if (sram_load || load_pend) begin
            capt_go        = 1'b1;
            load_pend_next = 1'b0;
            state_next     = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Chip selects pulse for exactly the ISSUE cycle; everything else holds its last value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg           <= '0;
      csb_n_q         <= 1'b1;
      sel_q           <= '0;
      sel_ok_q        <= 1'b0;
      rd0_q           <= 1'b0;
      rd1_q           <= 1'b0;
      sel_err         <= 1'b0;
      sram.macro_csb0 <= '1;
      sram.macro_csb1 <= '1;
      sram.web0       <= 1'b1;
      sram.web1       <= 1'b1;
      sram.wmask0     <= '0;
      sram.wmask1     <= '0;
      sram.addr0      <= '0;
      sram.addr1      <= '0;
      sram.din0       <= '0;
      sram.din1       <= '0;
    end else begin
      csb_n_q         <= csb_n;
      sram.macro_csb0 <= '1;
      sram.macro_csb1 <= '1;
      if (scan_en) begin
        shreg <= pkt_t'({shreg[PKT_W-2:0], scan_in});
      end else if (capt_go) begin
        if (rd0_q) shreg.din0 <= dout0_sel;
        if (rd1_q) shreg.din1 <= dout1_sel;
      end
      if (issue_go) begin
        sel_q           <= shreg.sel;
        sel_ok_q        <= sel_ok;
        rd0_q           <= sel_ok && !shreg.csb0 && shreg.web0;
        rd1_q           <= sel_ok && !shreg.csb1 && shreg.web1;
        sel_err         <= sel_err | !sel_ok;
        sram.macro_csb0 <= csb0_pick;
        sram.macro_csb1 <= csb1_pick;
        sram.web0       <= shreg.web0;
        sram.web1       <= shreg.web1;
        sram.wmask0     <= shreg.wmask0;
        sram.wmask1     <= shreg.wmask1;
        sram.addr0      <= shreg.addr0;
        sram.addr1      <= shreg.addr1;
        sram.din0       <= shreg.din0;
        sram.din1       <= shreg.din1;
      end
    end
  end

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// Randomized bench for sram_scan_ctrl: a behavioural SRAM array on the bus and a
// field-level reference model predicting every shifted-out packet and issue cycle.
module tb_sram_scan_ctrl;
  localparam int NM = 12;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn, scan_en, scan_in, scan_out, csb_n, sram_load, busy, sel_err;

  always #5 clk = ~clk;

  sram_scan_ctrl_if #(.NUM_MACROS(NM), .ADDR_W(AW), .DATA_W(DW)) sram_bus ();

  sram_scan_ctrl #(
    .NUM_MACROS(NM), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)
  ) dut (
    .clk(clk), .resetn(resetn), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(scan_out), .csb_n(csb_n), .sram_load(sram_load),
    .busy(busy), .sel_err(sel_err), .sram(sram_bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [111:0] got, input logic [111:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int k, input int a);
    return (32'(k) * 32'h9E3779B1) ^ (32'(a) * 32'h85EBCA6B) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural macro array: 8 words per macro, registered read data that holds.
  logic [31:0] env_mem [NM][8];
  logic [31:0] env_q0 [NM];
  logic [31:0] env_q1 [NM];

  always_comb begin
    sram_bus.dout0_bus = '0;
    sram_bus.dout1_bus = '0;
    for (int k = 0; k < NM; k++) begin
      sram_bus.dout0_bus[k*DW +: DW] = env_q0[k];
      sram_bus.dout1_bus[k*DW +: DW] = env_q1[k];
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NM; k++) begin
        env_q0[k] <= '0;
        env_q1[k] <= '0;
        for (int a = 0; a < 8; a++) env_mem[k][a] <= init_word(k, a);
      end
    end else begin
      for (int k = 0; k < NM; k++) begin
        if (!sram_bus.macro_csb0[k]) begin
          if (sram_bus.web0) env_q0[k] <= env_mem[k][sram_bus.addr0[2:0]];
          else for (int b = 0; b < 4; b++)
            if (sram_bus.wmask0[b])
              env_mem[k][sram_bus.addr0[2:0]][8*b +: 8] <= sram_bus.din0[8*b +: 8];
        end
        if (!sram_bus.macro_csb1[k]) begin
          if (sram_bus.web1) env_q1[k] <= env_mem[k][sram_bus.addr1[2:0]];
          else for (int b = 0; b < 4; b++)
            if (sram_bus.wmask1[b])
              env_mem[k][sram_bus.addr1[2:0]][8*b +: 8] <= sram_bus.din1[8*b +: 8];
        end
      end
    end
  end

  // Reference model state
  logic [31:0]  ref_mem [NM][8];
  logic [111:0] model_pkt;
  logic         sel_err_exp;

  logic [3:0]  f_sel, f_m0, f_m1;
  logic [15:0] f_a0, f_a1;
  logic [31:0] f_d0, f_d1;
  logic        f_c0, f_w0, f_c1, f_w1;

  task automatic ref_reset();
    model_pkt   = '0;
    sel_err_exp = 1'b0;
    for (int k = 0; k < NM; k++)
      for (int a = 0; a < 8; a++) ref_mem[k][a] = init_word(k, a);
  endtask

  task automatic set_f(input logic [3:0] s, input logic [15:0] a0, input logic [31:0] d0,
                       input logic c0, input logic w0, input logic [3:0] m0,
                       input logic [15:0] a1, input logic [31:0] d1,
                       input logic c1, input logic w1, input logic [3:0] m1);
    f_sel = s; f_a0 = a0; f_d0 = d0; f_c0 = c0; f_w0 = w0; f_m0 = m0;
    f_a1 = a1; f_d1 = d1; f_c1 = c1; f_w1 = w1; f_m1 = m1;
  endtask

  task automatic set_random();
    set_f(4'($urandom_range(0, 13)), 16'($urandom_range(0, 7)), $urandom,
          1'($urandom), 1'($urandom), 4'($urandom),
          16'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
  endtask

  // Called at a negedge; the bits seen on scan_out are the previous packet.
  task automatic shift_in(input logic [111:0] pkt);
    logic [111:0] got;
    got = '0;
    for (int i = 111; i >= 0; i--) begin
      got[i]  = scan_out;
      scan_en = 1'b1;
      scan_in = pkt[i];
      @(negedge clk);
    end
    scan_en = 1'b0;
    chk("scan_out_pkt", got, model_pkt);
    model_pkt = pkt;
  endtask

  task automatic run_txn(input int lowlen, input int ls, input int ll, input bit abort);
    logic [111:0]   pkt, cap;
    logic [NM-1:0]  e0, e1;
    logic [31:0]    r0, r1;
    logic           ok, rd0, rd1, abit;
    int             busy_n, extra, exp_busy;
    pkt = {f_sel, f_a0, f_d0, f_c0, f_w0, f_m0, f_a1, f_d1, f_c1, f_w1, f_m1};
    shift_in(pkt);
    ok  = int'(f_sel) < NM;
    rd0 = ok && !f_c0 && f_w0;
    rd1 = ok && !f_c1 && f_w1;
    e0 = '1;
    e1 = '1;
    r0 = '0;
    r1 = '0;
    if (ok) begin
      e0[f_sel] = f_c0;
      e1[f_sel] = f_c1;
      r0 = ref_mem[f_sel][f_a0[2:0]];
      r1 = ref_mem[f_sel][f_a1[2:0]];
      if (!f_c0 && !f_w0) ref_mem[f_sel][f_a0[2:0]] = merge(ref_mem[f_sel][f_a0[2:0]], f_d0, f_m0);
      if (!f_c1 && !f_w1) ref_mem[f_sel][f_a1[2:0]] = merge(ref_mem[f_sel][f_a1[2:0]], f_d1, f_m1);
    end else begin
      sel_err_exp = 1'b1;
    end
    cap = {f_sel, f_a0, rd0 ? r0 : f_d0, f_c0, f_w0, f_m0,
           f_a1, rd1 ? r1 : f_d1, f_c1, f_w1, f_m1};
    abit = 1'($urandom);
    exp_busy = !(rd0 || rd1) ? 1 : abort ? 2 : (ls > 3 ? ls : 3);
    busy_n = 0;
    extra  = 0;
    csb_n  = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (c == 1) begin
        chk("issue_csb0", 112'(sram_bus.macro_csb0), 112'(e0));
        chk("issue_csb1", 112'(sram_bus.macro_csb1), 112'(e1));
        chk("issue_bus",
            {sram_bus.web0, sram_bus.wmask0, sram_bus.addr0, sram_bus.din0,
             sram_bus.web1, sram_bus.wmask1, sram_bus.addr1, sram_bus.din1},
            {f_w0, f_m0, f_a0, f_d0, f_w1, f_m1, f_a1, f_d1});
      end else if (sram_bus.macro_csb0 != '1 || sram_bus.macro_csb1 != '1) begin
        extra++;
      end
      csb_n     = (c < lowlen) ? 1'b0 : 1'b1;
      sram_load = !abort && c >= ls && c < ls + ll;
      scan_en   = abort && c == 2;
      scan_in   = abit;
    end
    chk("busy_cycles", 112'(busy_n), 112'(exp_busy));
    chk("extra_issue", 112'(extra), '0);
    chk("sel_err", 112'(sel_err), 112'(sel_err_exp));
    model_pkt = abort ? {pkt[110:0], abit} : cap;
  endtask

  task automatic apply_reset();
    resetn    = 1'b0;
    scan_en   = 1'b0;
    scan_in   = 1'b0;
    csb_n     = 1'b1;
    sram_load = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    ref_reset();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_csb0"}, 112'(sram_bus.macro_csb0), 112'({NM{1'b1}}));
    chk({tag, "_csb1"}, 112'(sram_bus.macro_csb1), 112'({NM{1'b1}}));
    chk({tag, "_busy"}, 112'(busy), '0);
  endtask

  initial begin
    logic [111:0] pat, rnd;
    apply_reset();
    check_idle_outputs("rst");
    chk("rst_scan_out", 112'(scan_out), '0);
    chk("rst_sel_err", 112'(sel_err), '0);
    chk("rst_bus",
        {sram_bus.web0, sram_bus.wmask0, sram_bus.addr0, sram_bus.din0,
         sram_bus.web1, sram_bus.wmask1, sram_bus.addr1, sram_bus.din1},
        {1'b1, 4'h0, 16'h0, 32'h0, 1'b1, 4'h0, 16'h0, 32'h0});

    pat = {14{8'hA5}};
    rnd = {$urandom, $urandom, $urandom, 16'($urandom)};
    shift_in(pat);
    shift_in(rnd);

    set_f(4'd0, 16'd1, 32'd1, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0);
    run_txn(1, 3, 1, 1'b0);
    set_f(4'd0, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0, 16'd2, 32'd2, 1'b0, 1'b0, 4'hF);
    run_txn(2, 3, 1, 1'b0);
    set_f(4'd0, 16'd1, $urandom, 1'b0, 1'b1, 4'h0, 16'd2, $urandom, 1'b0, 1'b1, 4'h0);
    run_txn(1, 2, 3, 1'b0);
    set_f(4'd11, 16'd3, $urandom, 1'b0, 1'b1, 4'h0, 16'd4, $urandom, 1'b1, 1'b1, 4'h0);
    run_txn(10, 4, 2, 1'b0);
    set_f(4'd13, 16'd1, $urandom, 1'b0, 1'b0, 4'hF, 16'd1, $urandom, 1'b0, 1'b1, 4'h0);
    run_txn(1, 3, 1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      set_random();
      run_txn($urandom_range(1, 10), $urandom_range(2, 4), $urandom_range(1, 3),
              $urandom_range(0, 7) == 0);
    end

    // Reset while a read is waiting: nothing is captured and the chain clears.
    set_f(4'd5, 16'd2, $urandom, 1'b0, 1'b1, 4'h0, 16'd3, $urandom, 1'b0, 1'b1, 4'h0);
    shift_in({f_sel, f_a0, f_d0, f_c0, f_w0, f_m0, f_a1, f_d1, f_c1, f_w1, f_m1});
    csb_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wait_busy", 112'(busy), 112'(1));
    resetn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    chk("midrst_sel_err", 112'(sel_err), '0);
    csb_n = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    ref_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("postrst");

    for (int t = 0; t < 10; t++) begin
      set_random();
      run_txn($urandom_range(1, 10), $urandom_range(2, 4), $urandom_range(1, 3), 1'b0);
    end
    shift_in({$urandom, $urandom, $urandom, 16'($urandom)});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
